// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its instruction queue.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  // Sequencer states; exported on state_dbg so checkers can follow the FSM.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  // One buffered fetch result: instruction word, its PC and the fault flag.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue. The head entry is presented combinationally
// from storage. Flush empties the queue and wins over a same-cycle push/pop.
// The caller guarantees push is only raised when a slot is free or a pop
// happens in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               entry_in,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_pop;

  // A pop on an empty queue is a no-op.
  assign do_pop = pop && !empty;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // Pointer, count and storage update; storage is cleared on reset so the
  // head reads as zero until the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the PC, issues one icache request at a time over a
// req/gnt/rvalid handshake, buffers results in fetch_queue and serves decode.
//
// Handshake: icache_req/icache_addr are held until the cycle icache_req &&
// icache_gnt; exactly one icache_rvalid follows, no earlier than the next
// cycle. Decode consumes the head when instr_valid && !stall.
//
// A redirect flushes the queue and retargets the PC. If a granted request is
// still outstanding, its response is marked for discard with kill.
module fetch_seq_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         icache_req,
  output logic [31:0]  icache_addr,
  input  logic         icache_gnt,
  input  logic         icache_rvalid,
  input  logic [31:0]  icache_rdata,
  input  logic         icache_error,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  output logic         instr_fault,
  output fetch_state_t state_dbg
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int OW = CW + 1;

  fetch_state_t  state;
  logic [31:0]   pc;
  logic          kill;
  logic          req_q;

  fetch_entry_t  q_head;
  fetch_entry_t  q_in;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic          do_pop;
  logic          do_push;
  logic [OW-1:0] occ_after;
  logic          room;
  logic [31:0]   pc_inc;

  // Decode handshake and the accept condition for a returning response.
  assign do_pop  = !q_empty && !stall;
  assign do_push = (state == ST_WAIT) && icache_rvalid && !kill && !redirect_valid;

  // Occupancy once this cycle's push and pop have taken effect.
  assign occ_after = {1'b0, q_count} + OW'(do_push) - OW'(do_pop);
  assign room      = (occ_after < OW'(BUF_DEPTH));
  assign pc_inc    = pc + 32'(INSTR_BYTES);

  assign q_in = '{instr: icache_rdata, pc: pc, fault: icache_error};

  fetch_queue #(
    .DEPTH (BUF_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (do_push && (!q_full || do_pop)),
    .entry_in (q_in),
    .pop      (do_pop),
    .flush    (redirect_valid),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  // Sequencer FSM: state, PC, kill flag and the registered request strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC & ~32'h3;
      kill  <= 1'b0;
      req_q <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~32'h3;
      case (state)
        ST_WAIT: begin
          if (icache_rvalid) begin
            state <= ST_REQ;
            kill  <= 1'b0;
            req_q <= 1'b1;
          end else begin
            kill  <= 1'b1;
            req_q <= 1'b0;
          end
        end
        ST_REQ: begin
          if (icache_gnt) begin
            state <= ST_WAIT;
            kill  <= 1'b1;
            req_q <= 1'b0;
          end else begin
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_REQ;
          req_q <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_REQ;
          req_q <= 1'b1;
        end
        ST_REQ: begin
          if (icache_gnt) begin
            state <= ST_WAIT;
            req_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (icache_rvalid) begin
            if (kill) kill <= 1'b0;
            else      pc   <= pc_inc;
            if (!kill && icache_error) begin
              state <= ST_FAULT;
              req_q <= 1'b0;
            end else if (room) begin
              state <= ST_REQ;
              req_q <= 1'b1;
            end else begin
              state <= ST_HOLD;
              req_q <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (room) begin
            state <= ST_REQ;
            req_q <= 1'b1;
          end
        end
        ST_FAULT: begin
          req_q <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign icache_req  = req_q;
  assign icache_addr = pc;
  assign state_dbg   = state;

  assign instr_valid = !q_empty;
  assign instr       = q_head.instr;
  assign instr_pc    = q_head.pc;
  assign instr_fault = q_head.fault;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl. Each vector row gives the inputs for one
// cycle and the outputs expected in that same cycle (before the clock edge).
// Inputs are driven and outputs sampled on the falling edge.
module tb_fetch_seq_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0004;
  localparam logic [31:0] D2 = 32'h3333_0008;
  localparam logic [31:0] D3 = 32'h4444_0100;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        stall, redirect_valid, icache_gnt, icache_rvalid, icache_error;
  logic [31:0] redirect_pc, icache_rdata;

  logic         a_req, a_valid, a_fault;
  logic [31:0]  a_addr, a_instr, a_pc;
  fetch_state_t a_state;
  logic         b_req, b_valid, b_fault;
  logic [31:0]  b_addr, b_instr, b_pc;
  fetch_state_t b_state;

  fetch_seq_ctrl u_dut_a (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .icache_req(a_req), .icache_addr(a_addr), .icache_gnt(icache_gnt),
    .icache_rvalid(icache_rvalid), .icache_rdata(icache_rdata),
    .icache_error(icache_error),
    .instr_valid(a_valid), .instr(a_instr), .instr_pc(a_pc),
    .instr_fault(a_fault), .state_dbg(a_state)
  );

  fetch_seq_ctrl #(.RESET_PC(WRAP_PC), .BUF_DEPTH(2)) u_dut_b (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .icache_req(b_req), .icache_addr(b_addr), .icache_gnt(icache_gnt),
    .icache_rvalid(icache_rvalid), .icache_rdata(icache_rdata),
    .icache_error(icache_error),
    .instr_valid(b_valid), .instr(b_instr), .instr_pc(b_pc),
    .instr_fault(b_fault), .state_dbg(b_state)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic        rs;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_fault;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  function automatic vec_t mk(
    input logic rs, input logic st, input logic rv, input logic [31:0] rpc,
    input logic g, input logic rval, input logic [31:0] rd, input logic er,
    input logic eq, input logic [31:0] ea, input logic ev,
    input logic [31:0] ei, input logic [31:0] ep, input logic ef);
    vec_t v;
    v.rs = rs; v.stall = st; v.rv = rv; v.rpc = rpc; v.gnt = g;
    v.rvalid = rval; v.rdata = rd; v.err = er;
    v.e_req = eq; v.e_addr = ea; v.e_valid = ev;
    v.e_instr = ei; v.e_pc = ep; v.e_fault = ef;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step_id, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    icache_gnt = 1'b0; icache_rvalid = 1'b0; icache_rdata = '0; icache_error = 1'b0;
  endtask

  // Leaves the bench on a falling edge with rst just released; both DUTs in IDLE.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    step_id++;
    chk("rst_req",   32'(a_req),   32'd0);
    chk("rst_addr",  a_addr,       32'h0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_instr", a_instr,      32'h0);
    chk("rst_pc",    a_pc,         32'h0);
    chk("rst_fault", 32'(a_fault), 32'd0);
    chk("rst_addr_b", b_addr,      WRAP_PC);
    rst = 1'b1;
  endtask

  // Apply one vector at a falling edge, check outputs, advance one cycle.
  task automatic apply(input vec_t v, input bit sel_b);
    step_id++;
    stall = v.stall; redirect_valid = v.rv; redirect_pc = v.rpc;
    icache_gnt = v.gnt; icache_rvalid = v.rvalid;
    icache_rdata = v.rdata; icache_error = v.err;
    chk("icache_req",  32'(sel_b ? b_req : a_req),     32'(v.e_req));
    chk("icache_addr", sel_b ? b_addr : a_addr,        v.e_addr);
    chk("instr_valid", 32'(sel_b ? b_valid : a_valid), 32'(v.e_valid));
    if (v.e_valid) begin
      chk("instr",       sel_b ? b_instr : a_instr,        v.e_instr);
      chk("instr_pc",    sel_b ? b_pc : a_pc,              v.e_pc);
      chk("instr_fault", 32'(sel_b ? b_fault : a_fault),   32'(v.e_fault));
    end
    @(negedge clk);
  endtask

  // ---------------- test ----------------
  initial begin
    idle_inputs();

    // Streaming fetch, gnt tied high, rvalid one cycle after gnt.
    tbl.push_back(mk(1,0,0,0, 1,0,0,0, 0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,0,0, 1,32'h0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,D0,0, 0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,0,0, 1,32'h4,1,D0,32'h0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,D1,0, 0,32'h4,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,0,0, 1,32'h8,1,D1,32'h4,0));
    tbl.push_back(mk(0,0,0,0, 1,1,D2,0, 0,32'h8,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'hC,1,D2,32'h8,0));
    // Backpressure: stall for 10 cycles fills the queue and parks in HOLD.
    tbl.push_back(mk(1,0,0,0, 1,0,0,0, 0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,0,0, 1,32'h0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,D0,0, 0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 1,0,0,0, 1,32'h4,1,D0,32'h0,0));
    tbl.push_back(mk(0,1,0,0, 1,1,D1,0, 0,32'h4,1,D0,32'h0,0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0,1,0,0, 1,0,0,0, 0,32'h8,1,D0,32'h0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,0,0, 0,32'h8,1,D0,32'h0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,0,0, 1,32'h8,1,D1,32'h4,0));
    tbl.push_back(mk(0,0,0,0, 1,1,D2,0, 0,32'h8,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'hC,1,D2,32'h8,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'hC,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rs) do_reset();
      apply(tbl[i], 1'b0);
    end

    // Redirect while the 0x4 response is pending; stale data is dropped.
    // The first instruction after the redirect is the value zero.
    do_reset();
    apply(mk(0,0,0,0,           1,0,0,0,   0,32'h0,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,0,0,0,   1,32'h0,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,1,D0,0,  0,32'h0,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,0,0,0,   1,32'h4,1,D0,32'h0,0), 1'b0);
    apply(mk(0,0,1,32'h1000,    1,0,0,0,   0,32'h4,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,1,D1,0,  0,32'h1000,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,0,0,0,   1,32'h1000,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,1,32'h0,0, 0,32'h1000,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           0,0,0,0,   1,32'h1004,1,32'h0,32'h1000,0), 1'b0);
    apply(mk(0,0,0,0,           0,0,0,0,   1,32'h1004,0,0,0,0), 1'b0);

    // Redirect in the same cycle as rvalid and a pop; target low bits dropped.
    do_reset();
    apply(mk(0,0,0,0,           1,0,0,0,   0,32'h0,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,0,0,0,   1,32'h0,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,1,D0,0,  0,32'h0,0,0,0,0), 1'b0);
    apply(mk(0,1,0,0,           1,0,0,0,   1,32'h4,1,D0,32'h0,0), 1'b0);
    apply(mk(0,0,1,32'h2002,    1,1,D1,0,  0,32'h4,1,D0,32'h0,0), 1'b0);
    apply(mk(0,0,0,0,           1,0,0,0,   1,32'h2000,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,1,D2,0,  0,32'h2000,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           0,0,0,0,   1,32'h2004,1,D2,32'h2000,0), 1'b0);

    // Fetch fault on the 0x8 response; requests stop until a redirect.
    do_reset();
    apply(mk(0,0,0,0,           1,0,0,0,   0,32'h0,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,0,0,0,   1,32'h0,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,1,D0,0,  0,32'h0,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,0,0,0,   1,32'h4,1,D0,32'h0,0), 1'b0);
    apply(mk(0,0,0,0,           1,1,D1,0,  0,32'h4,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,0,0,0,   1,32'h8,1,D1,32'h4,0), 1'b0);
    apply(mk(0,0,0,0,           1,1,D2,1,  0,32'h8,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,0,0,0,   0,32'hC,1,D2,32'h8,1), 1'b0);
    apply(mk(0,0,0,0,           1,1,D1,0,  0,32'hC,0,0,0,0), 1'b0);
    apply(mk(0,0,1,32'h100,     1,0,0,0,   0,32'hC,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,0,0,0,   1,32'h100,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           1,1,D3,0,  0,32'h100,0,0,0,0), 1'b0);
    apply(mk(0,0,0,0,           0,0,0,0,   1,32'h104,1,D3,32'h100,0), 1'b0);

    // PC wrap with a 3-cycle grant delay (second instance, RESET_PC near top).
    // An error strobe without rvalid is ignored while waiting.
    do_reset();
    apply(mk(0,0,0,0,           0,0,0,0,   0,WRAP_PC,0,0,0,0), 1'b1);
    apply(mk(0,0,0,0,           0,0,0,0,   1,WRAP_PC,0,0,0,0), 1'b1);
    apply(mk(0,0,0,0,           0,0,0,0,   1,WRAP_PC,0,0,0,0), 1'b1);
    apply(mk(0,0,0,0,           0,0,0,0,   1,WRAP_PC,0,0,0,0), 1'b1);
    apply(mk(0,0,0,0,           1,0,0,0,   1,WRAP_PC,0,0,0,0), 1'b1);
    apply(mk(0,0,0,0,           0,0,0,1,   0,WRAP_PC,0,0,0,0), 1'b1);
    apply(mk(0,0,0,0,           0,1,D0,0,  0,WRAP_PC,0,0,0,0), 1'b1);
    apply(mk(0,0,0,0,           1,0,0,0,   1,32'hFFFF_FFFC,1,D0,WRAP_PC,0), 1'b1);
    apply(mk(0,0,0,0,           0,1,D1,0,  0,32'hFFFF_FFFC,0,0,0,0), 1'b1);
    apply(mk(0,0,0,0,           1,0,0,0,   1,32'h0,1,D1,32'hFFFF_FFFC,0), 1'b1);
    apply(mk(0,0,0,0,           0,1,D2,0,  0,32'h0,0,0,0,0), 1'b1);
    apply(mk(0,0,0,0,           0,0,0,0,   1,32'h4,1,D2,32'h0,0), 1'b1);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
Fetch sequencer between the instruction cache and decode. Owns the program counter and issues one icache request at a time with a req/gnt/rvalid handshake. Buffers returned instructions in a small in-order queue tagged with PC and fault status, and presents them to decode with stall backpressure. Handles redirects (branch/exception) by flushing the queue and discarding in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
BUF_DEPTH, 2, instruction queue entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
stall  in  1  decode cannot accept; head entry held
redirect_valid  in  1  one-cycle redirect strobe
redirect_pc  in  32  redirect target (bits [1:0] ignored, forced 0)
icache_req  out  1  request valid
icache_addr  out  32  request address, word aligned
icache_gnt  in  1  request accepted this cycle (address sampled only on req&&gnt)
icache_rvalid  in  1  response valid (earliest one cycle after gnt)
icache_rdata  in  32  response instruction
icache_error  in  1  response fault, qualified by icache_rvalid
instr_valid  out  1  queue head valid
instr  out  32  head instruction
instr_pc  out  32  head PC
instr_fault  out  1  head carries fetch fault

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE, queue empty, kill=0; icache_req=0, icache_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, instr_fault=0.
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: one cycle after reset release -> REQ.
- REQ: icache_req=1, icache_addr=pc. On gnt -> WAIT. Without gnt, stay in REQ.
- WAIT: icache_req=0. On rvalid with kill=0, push {rdata, pc, error} and set pc=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0). On rvalid with kill=1, drop the response, clear kill, leave pc unchanged. After rvalid:
  - error pushed -> FAULT;
  - else occupancy after this cycle's push/pop < BUF_DEPTH -> REQ;
  - else -> HOLD.
- HOLD: occupancy < BUF_DEPTH -> REQ.
- FAULT: no requests. Leave only on redirect.
- Invariant: at most one outstanding request. A request is issued only when a queue slot is free, so a push never overflows.
- Queue output: instr_valid = not empty; instr/instr_pc/instr_fault = head, combinational from storage. Pop when instr_valid && !stall. Simultaneous push and pop on a full queue is legal; occupancy unchanged.
- Redirect (highest priority, any state): queue flushed, pc=redirect_pc&~3.
  - From WAIT with no rvalid that cycle: kill=1, stay WAIT.
  - From WAIT with rvalid that cycle: the response is dropped, kill stays 0, next state REQ.
  - From REQ with gnt that cycle: kill=1, -> WAIT.
  - From REQ without gnt, or from IDLE/HOLD/FAULT: -> REQ with the new pc next cycle. Changing the address before grant is legal per the icache contract.
  - Same-cycle pop is cancelled by the flush; instr_valid=0 next cycle.
- Instruction value 0 gets no special treatment; validity comes only from the queue.
- icache_error without rvalid is ignored.
- Reset mid-transaction abandons the outstanding request; responses arriving after reset release in IDLE/REQ are ignored.

Decomposition:
- Package fetch_pkg: state enum (IDLE, REQ, WAIT, HOLD, FAULT), fetch_entry_t struct {instr[31:0], pc[31:0], fault}, constants INSTR_BYTES=4, XLEN=32.
- Sub-module fetch_queue: BUF_DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, full, empty, count. Async active-low reset clears pointers and count.

Test Plan:
- Reset then streaming fetch: gnt tied 1, rvalid one cycle after gnt, stall=0 -> addresses 0x0, 0x4, 0x8 in order; instr_pc matches; instr_valid=1 from the first response+1 cycle.
- Backpressure: stall=1 for 10 cycles while fetching -> queue fills to 2, icache_req=0 (HOLD), head held stable; release stall -> 0x8 requested next, no loss or duplication.
- Redirect during WAIT: redirect_pc=0x1000 while the 0x4 response is pending -> 0x4 data dropped, queue empty, next request 0x1000, first delivered instr_pc=0x1000.
- Redirect same cycle as rvalid and pop: redirect_pc=0x2002 -> response dropped, instr_valid=0 next cycle, next icache_addr=0x2000.
- Fetch fault: error=1 with the 0x8 response -> entry delivered with instr_fault=1, no further icache_req until redirect to 0x100 resumes at 0x100.
- PC wrap and grant delay: RESET_PC=0xFFFF_FFF8, gnt delayed 3 cycles -> icache_addr stable while waiting; sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
